// File: rtl/score_pkg.sv
// Shared constants, FSM state type and clamp helper for the score display.
// Imported by bin2bcd_seq and score_digit_ctrl.
package score_pkg;

    localparam int DIGIT_W      = 30;
    localparam int DIGIT_H      = 30;
    localparam int GLYPH_PIXELS = 900;
    localparam int NUM_DIGITS   = 6;
    localparam int SHIFT_CYCLES = 20;

    localparam logic [19:0] MAX_SCORE = 20'd999999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [19:0] clamp_score(input logic [19:0] v);
        return (v > MAX_SCORE) ? MAX_SCORE : v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary to BCD converter (shift-add-3), 20 SHIFT + 1 DONE.
// Ports: clk, reset (async high), i_start, i_bin[19:0] -> o_busy, o_done, o_bcd[23:0].
// A start is accepted in IDLE or DONE; the input is clamped to 999999.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [19:0] i_bin,
    output logic        o_busy,
    output logic        o_done,
    output logic [23:0] o_bcd
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [43:0] r_sr;
    logic [43:0] w_sr_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;
    logic [23:0] w_adj;

    // BCD part lives in r_sr[43:20], unconverted binary in r_sr[19:0].
    always_comb begin
        w_adj = r_sr[43:20];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_sr[20 + 4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_sr[20 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = SHIFT;
                    w_sr_nxt    = {24'd0, clamp_score(i_bin)};
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                w_sr_nxt  = {w_adj, r_sr[19:0]} << 1;
                w_cnt_nxt = r_cnt + 5'd1;
                if (r_cnt == 5'(SHIFT_CYCLES - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_start) begin
                    w_state_nxt = SHIFT;
                    w_sr_nxt    = {24'd0, clamp_score(i_bin)};
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == DONE);
    assign o_bcd  = r_sr[43:20];

endmodule

// File: rtl/score_digit_ctrl.sv
// Score display sequencer: BCD conversion with pending load, shadow/frame
// double buffer, and VGA pixel decode to place select + glyph address.
// Ports: clk, reset, score, score_valid, frame_start, px, py -> busy,
// digit_sel[5:0], glyph_addr[12:0], d_ones..d_hthousands.
// Optional macro SCORE_LZB_EN enables leading-zero blanking of digit_sel.
module score_digit_ctrl
    import score_pkg::*;
#(
    parameter logic [9:0] X0 = 10'd200,
    parameter logic [8:0] Y0 = 9'd20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] score,
    input  logic        score_valid,
    input  logic        frame_start,
    input  logic [9:0]  px,
    input  logic [8:0]  py,
    output logic        busy,
    output logic [5:0]  digit_sel,
    output logic [12:0] glyph_addr,
    output logic [3:0]  d_ones,
    output logic [3:0]  d_tens,
    output logic [3:0]  d_hundreds,
    output logic [3:0]  d_thousands,
    output logic [3:0]  d_tthousands,
    output logic [3:0]  d_hthousands
);

    localparam logic [9:0] W = 10'(DIGIT_W);
    localparam logic [8:0] H = 9'(DIGIT_H);

    logic        w_busy;
    logic        w_done;
    logic [23:0] w_bcd;
    logic        w_start;
    logic [19:0] w_start_val;

    logic        r_pend_v;
    logic [19:0] r_pend;
    logic [23:0] r_shadow;
    logic [23:0] r_disp;

    // A strobe during DONE starts directly: same result as pending
    // being written and consumed, and keeps busy continuous.
    assign w_start     = (!w_busy || w_done) && (score_valid || r_pend_v);
    assign w_start_val = score_valid ? score : r_pend;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_bin   (w_start_val),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_v <= 1'b0;
            r_pend   <= '0;
            r_shadow <= '0;
            r_disp   <= '0;
        end else begin
            if (w_start) begin
                r_pend_v <= 1'b0;
            end else if (score_valid) begin
                r_pend_v <= 1'b1;
                r_pend   <= clamp_score(score);
            end
            if (w_done) begin
                r_shadow <= w_bcd;
            end
            // Old shadow is copied when swap and DONE coincide.
            if (frame_start) begin
                r_disp <= r_shadow;
            end
        end
    end

    logic        w_in;
    logic [9:0]  w_dx;
    logic [8:0]  w_dy;
    logic [2:0]  w_pos;
    logic [9:0]  w_col;
    logic [5:0]  w_sel;
    logic [5:0]  w_mask;
    logic [12:0] w_addr;

    assign w_in = (px >= X0) && (px < X0 + 10'd180) &&
                  (py >= Y0) && (py < Y0 + H);
    assign w_dx = px - X0;
    assign w_dy = py - Y0;

    // Constant compare chain replaces divide/mod by 30.
    always_comb begin
        w_pos = 3'd0;
        w_col = w_dx;
        if (w_dx >= 5*W) begin
            w_pos = 3'd5;
            w_col = w_dx - 5*W;
        end else if (w_dx >= 4*W) begin
            w_pos = 3'd4;
            w_col = w_dx - 4*W;
        end else if (w_dx >= 3*W) begin
            w_pos = 3'd3;
            w_col = w_dx - 3*W;
        end else if (w_dx >= 2*W) begin
            w_pos = 3'd2;
            w_col = w_dx - 2*W;
        end else if (w_dx >= W) begin
            w_pos = 3'd1;
            w_col = w_dx - W;
        end
    end

    // Position 0 is the leftmost place (hundred-thousands, bit 5).
    assign w_sel = 6'b100000 >> w_pos;

    // row*30 = row*32 - row*2
    assign w_addr = ({4'd0, w_dy} << 5) - ({4'd0, w_dy} << 1) +
                    {3'd0, w_col};

`ifdef SCORE_LZB_EN
    // Bit k stays enabled when any displayed digit at k or above is non-zero.
    always_comb begin
        logic w_nz;
        w_nz      = 1'b0;
        w_mask    = 6'b000001;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_nz      = w_nz | (|r_disp[4*k +: 4]);
            w_mask[k] = w_nz;
        end
    end
`else
    assign w_mask = 6'b111111;
`endif

    logic [5:0]  r_sel;
    logic [12:0] r_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel  <= '0;
            r_addr <= '0;
        end else if (w_in) begin
            r_sel  <= w_sel & w_mask;
            r_addr <= w_addr;
        end else begin
            r_sel  <= '0;
            r_addr <= '0;
        end
    end

    assign busy         = w_busy;
    assign digit_sel    = r_sel;
    assign glyph_addr   = r_addr;
    assign d_ones       = r_disp[3:0];
    assign d_tens       = r_disp[7:4];
    assign d_hundreds   = r_disp[11:8];
    assign d_thousands  = r_disp[15:12];
    assign d_tthousands = r_disp[19:16];
    assign d_hthousands = r_disp[23:20];

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Randomized + directed bench for score_digit_ctrl against a behavioural model.
// Honors SCORE_LZB_EN the same way as the design.
module tb_score_digit_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] score = '0;
    logic        score_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  px = '0;
    logic [8:0]  py = '0;
    logic        busy;
    logic [5:0]  digit_sel;
    logic [12:0] glyph_addr;
    logic [3:0]  d_ones, d_tens, d_hundreds;
    logic [3:0]  d_thousands, d_tthousands, d_hthousands;

    always #5 clk = ~clk;

    score_digit_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .score        (score),
        .score_valid  (score_valid),
        .frame_start  (frame_start),
        .px           (px),
        .py           (py),
        .busy         (busy),
        .digit_sel    (digit_sel),
        .glyph_addr   (glyph_addr),
        .d_ones       (d_ones),
        .d_tens       (d_tens),
        .d_hundreds   (d_hundreds),
        .d_thousands  (d_thousands),
        .d_tthousands (d_tthousands),
        .d_hthousands (d_hthousands)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dig(input int v, input int k);
        int t;
        t = v;
        for (int i = 0; i < k; i++) t = t / 10;
        return t % 10;
    endfunction

    // Model: conversion is a countdown of 21 busy cycles, the value is an
    // integer and digits come from decimal arithmetic.
    int m_left = 0, m_cur = 0, m_pend = 0, m_shadow = 0, m_disp = 0;
    bit m_pend_v = 0;
    int m_sel = 0, m_addr = 0;

    always @(posedge clk or posedge reset) begin : mdl
        int cl, dx, dy, p, msd;
        bit done_now, can_start;
        if (reset) begin
            m_left = 0; m_cur = 0; m_pend = 0; m_pend_v = 0;
            m_shadow = 0; m_disp = 0; m_sel = 0; m_addr = 0;
        end else begin
            cl = (int'(score) > 999999) ? 999999 : int'(score);
            dx = int'(px) - 200;
            dy = int'(py) - 20;
            if (dx >= 0 && dx < 180 && dy >= 0 && dy < 30) begin
                p = dx / 30;
                m_sel = 1 << (5 - p);
                m_addr = dy * 30 + dx % 30;
`ifdef SCORE_LZB_EN
                msd = 0;
                for (int k = 0; k < 6; k++)
                    if (dig(m_disp, k) != 0) msd = k;
                if (5 - p > msd) m_sel = 0;
`endif
            end else begin
                m_sel = 0;
                m_addr = 0;
            end
            if (frame_start) m_disp = m_shadow;
            done_now = (m_left == 1);
            if (done_now) m_shadow = m_cur;
            can_start = (m_left == 0) || done_now;
            if (can_start && (score_valid || m_pend_v)) begin
                m_cur = score_valid ? cl : m_pend;
                m_pend_v = 0;
                m_left = 21;
            end else begin
                if (m_left > 0) m_left--;
                if (score_valid) begin
                    m_pend = cl;
                    m_pend_v = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_left > 0);
            chk("d_ones", d_ones, dig(m_disp, 0));
            chk("d_tens", d_tens, dig(m_disp, 1));
            chk("d_hundreds", d_hundreds, dig(m_disp, 2));
            chk("d_thousands", d_thousands, dig(m_disp, 3));
            chk("d_tthousands", d_tthousands, dig(m_disp, 4));
            chk("d_hthousands", d_hthousands, dig(m_disp, 5));
            chk("digit_sel", digit_sel, m_sel);
            chk("glyph_addr", glyph_addr, m_addr);
        end
    end

    int run = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (busy) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [19:0] v);
        score = v;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    function automatic logic [23:0] shown();
        return {d_hthousands, d_tthousands, d_thousands,
                d_hundreds, d_tens, d_ones};
    endfunction

    logic [5:0] acc;
    logic [5:0] exp42, exp0;

    initial begin
`ifdef SCORE_LZB_EN
        exp42 = 6'b000011;
        exp0  = 6'b000001;
`else
        exp42 = 6'b111111;
        exp0  = 6'b111111;
`endif
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_digits", shown(), 0);
        chk("rst_sel", digit_sel, 0);
        chk("rst_addr", glyph_addr, 0);
        chk_en = 1;

        load(20'd123456);
        repeat (25) tick();
        frame();
        chk("t1_digits", shown(), 24'h123456);
        chk("t1_busy_len", last_run, 21);

        px = 10'd235; py = 9'd22; tick();
        chk("pix_sel", digit_sel, 6'b010000);
        chk("pix_addr", glyph_addr, 65);
        px = 10'd379; py = 9'd49; tick();
        chk("pix_last_sel", digit_sel, 6'b000001);
        chk("pix_last_addr", glyph_addr, 899);
        px = 10'd380; py = 9'd20; tick();
        chk("pix_out_sel", digit_sel, 0);
        chk("pix_out_addr", glyph_addr, 0);
        px = 10'd199; tick();
        chk("pix_left_sel", digit_sel, 0);

        load(20'hFFFFF);
        repeat (25) tick();
        frame();
        chk("clamp_digits", shown(), 24'h999999);

        load(20'd100);
        repeat (4) tick();
        load(20'd250);
        repeat (2) tick();
        load(20'd777);
        repeat (14) tick();
        frame();
        chk("bb_first", shown(), 24'h000100);
        repeat (25) tick();
        frame();
        chk("bb_second", shown(), 24'h000777);
        chk("bb_busy_len", last_run, 42);

        load(20'd500);
        repeat (2) tick();
        load(20'd600);
        repeat (6) tick();
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_digits", shown(), 0);
        tick();
        reset = 1'b0;
        repeat (30) tick();
        chk("abort_no_pend", busy, 0);
        frame();
        chk("abort_frame", shown(), 0);

        load(20'd42);
        repeat (25) tick();
        frame();
        chk("lzb42_digits", shown(), 24'h000042);
        acc = '0;
        py = 9'd25;
        for (int x = 200; x < 380; x++) begin
            px = 10'(x);
            tick();
            acc = acc | digit_sel;
        end
        chk("lzb42_scan", acc, exp42);

        load(20'd0);
        repeat (25) tick();
        frame();
        acc = '0;
        for (int x = 200; x < 380; x++) begin
            px = 10'(x);
            tick();
            acc = acc | digit_sel;
        end
        chk("lzb0_scan", acc, exp0);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom % 600 == 0);
            score = ($urandom % 2 == 0) ? 20'($urandom % 1048576)
                                        : 20'($urandom % 1000000);
            score_valid = ($urandom % 10 == 0);
            frame_start = ($urandom % 20 == 0);
            px = 10'(190 + $urandom % 200);
            py = 9'(15 + $urandom % 40);
            tick();
        end
        reset = 1'b0;
        score_valid = 1'b0;
        frame_start = 1'b0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
